reaction_controller: RTL
========================

Name: reaction_controller

Overview:
Top-level sequencer for the reaction tester. Consumes single-cycle button/start pulses from the debouncers and runs a pseudo-random foreperiod, then lights the stimulus LED. It measures press latency in milliseconds and reports a result, a false start or a timeout. It sits between the debouncer outputs and the display/AXI register logic.

Parameters:
FREQ, 100_000_000, clock frequency in Hz; FREQ/1000 must be an integer.
MIN_DELAY_MS, 1000, fixed part of the foreperiod in ms.
RAND_BITS, 10, width of the random foreperiod add-on (0..2^RAND_BITS-1 ms); 0 disables it.
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.
TIMEOUT_MS, 9999, maximum reaction time before abort.
RESULT_W, 14, result width; must satisfy 2^RESULT_W > TIMEOUT_MS.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_pulse  in  1  one-cycle debounced start request
button_pulse  in  1  one-cycle debounced response press
abort  in  1  level; forces return to IDLE
led  out  1  stimulus LED
busy  out  1  high in WAIT and STIM
result_ms  out  RESULT_W  last measured reaction time, held until next valid result
result_valid  out  1  one-cycle pulse when result_ms updates
false_start  out  1  sticky flag; press during foreperiod
timeout  out  1  sticky flag; no press within TIMEOUT_MS
state  out  3  current state encoding, for debug/status register

Behaviour:
- Reset (async, rst=1): state=IDLE, led=0, busy=0, result_ms=0, result_valid=0, false_start=0, timeout=0, LFSR=LFSR_SEED, counters=0. Reset mid-run aborts the trial immediately with no result.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock in every state except reset.
- ms tick: prescaler counts 0..FREQ/1000-1 and pulses tick on the terminal count. Prescaler is cleared on every state entry, so the first tick comes exactly FREQ/1000 cycles after entry.
- States: IDLE=0, WAIT=1, STIM=2, DONE=3, FALSE=4, TOUT=5.
- IDLE/DONE/FALSE/TOUT, start_pulse:
  - go to WAIT next cycle;
  - load delay_ms = MIN_DELAY_MS + LFSR[RAND_BITS-1:0] as sampled that cycle;
  - clear false_start and timeout;
  - keep result_ms.
- WAIT: decrement delay_ms on each tick. On the tick where delay_ms reaches 0, go to STIM with led=1 from the next cycle and ms_count=0.
- WAIT, button_pulse: go to FALSE, false_start=1, led stays 0, no result_valid.
- STIM, button_pulse at cycle N:
  - result_ms = ms_count, excluding any tick in cycle N;
  - result_valid=1 and led=0 at N+1;
  - state=DONE.
- STIM: increment ms_count on tick. When ms_count would reach TIMEOUT_MS, go to TOUT with timeout=1, led=0, result_ms=TIMEOUT_MS and result_valid pulsed.
- start_pulse in WAIT/STIM: ignored.
- button_pulse in IDLE/DONE/FALSE/TOUT: ignored.
- Same-cycle start_pulse and button_pulse in IDLE: start wins, button ignored.
- Same-cycle button_pulse and final WAIT tick: the button wins, giving a false start.
- abort=1: next state IDLE from any state, led=0, flags and result_ms unchanged. abort has priority over all other events.
- busy is combinational from state.
- All other outputs are registered.

Decomposition:
- Package reaction_pkg: state enum/localparams (3-bit), LFSR tap mask, and the ms_div constant function FREQ/1000.
- Sub-module ms_tick_gen (FREQ, clear, tick): the prescaler.
- The FSM, LFSR and ms counters stay in reaction_controller.

Test Plan:
Common bench settings: FREQ=10_000 (10 cycles/ms), MIN_DELAY_MS=3, RAND_BITS=0, TIMEOUT_MS=20.
- Normal run: start at t0 -> led rises at t0+1+30 cycles (±1). Button pressed 57 cycles after led rise -> result_ms=5, result_valid pulse one cycle later, led=0, state=DONE.
- False start: start, then button 15 cycles later -> state=FALSE, false_start=1, led never rises, no result_valid, result_ms keeps its prior value.
- Timeout: start, no button -> 200 cycles after led rise, state=TOUT, timeout=1, result_ms=20, one result_valid pulse. A later button is ignored.
- Simultaneous events: start+button in the same IDLE cycle -> WAIT with false_start=0. A button on the final WAIT tick cycle -> FALSE.
- Abort/reset: abort during STIM -> IDLE, led=0, no result_valid. rst asserted mid-WAIT -> all outputs 0 asynchronously, LFSR=16'hACE1. After release, a start works normally.
- Random foreperiod: RAND_BITS=10, issue 50 starts -> every foreperiod in [3,1026] ms × 10 cycles and matches the reference LFSR model value.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction tester sequencer.
package reaction_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_STIM  = 3'd2,
      S_DONE  = 3'd3,
      S_FALSE = 3'd4,
      S_TOUT  = 3'd5
   } state_t;

   // Feedback taps 16,14,13,11 of x^16 + x^14 + x^13 + x^11 + 1 (bit 16 = MSB)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Clock cycles per millisecond
   function automatic int ms_div(input int freq);
      return freq / 1000;
   endfunction

   // One Fibonacci step: shift toward the MSB, XOR of the tapped bits enters at bit 0
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/reaction_controller_ms_tick_gen.sv
// Millisecond prescaler. A clear restarts the count in the same cycle, so the
// first tick after a clear lands exactly one millisecond of cycles later.
module ms_tick_gen
   import reaction_pkg::*;
#(
   parameter int FREQ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int               DIV   = ms_div(FREQ);
   localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] TC    = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_eff;

   assign cnt_eff = clear ? '0 : cnt_q;
   assign tick    = (cnt_eff == TC);

   // Count 0..DIV-1 and wrap on the terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (tick)
         cnt_q <= '0;
      else
         cnt_q <= cnt_eff + CNT_W'(1);
   end

endmodule

// File: rtl/reaction_controller.sv
// Reaction tester sequencer: random foreperiod, stimulus LED, latency in ms.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | waiting for start after reset or abort
//   WAIT   | foreperiod running, LED off; press = false start
//   STIM   | LED on, counting reaction milliseconds
//   DONE   | valid result captured, waiting for next start
//   FALSE  | press during foreperiod, waiting for next start
//   TOUT   | no press within the timeout, waiting for next start
module reaction_controller
   import reaction_pkg::*;
#(
   parameter int          FREQ         = 100_000_000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          RAND_BITS    = 10,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          TIMEOUT_MS   = 9999,
   parameter int          RESULT_W     = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_pulse,
   input  logic                button_pulse,
   input  logic                abort,
   output logic                led,
   output logic                busy,
   output logic [RESULT_W-1:0] result_ms,
   output logic                result_valid,
   output logic                false_start,
   output logic                timeout,
   output logic [2:0]          state
);

   localparam int DELAY_W = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS) + 1);

   state_t              state_q;
   logic [15:0]         lfsr_q;
   logic [DELAY_W-1:0]  delay_q;
   logic [RESULT_W-1:0] ms_count;
   logic [DELAY_W-1:0]  rand_ms;
   logic                entry_q;
   logic                tick;

   // entry_q is high in the first cycle of every newly entered state
   ms_tick_gen #(.FREQ(FREQ)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (entry_q),
      .tick  (tick)
   );

   if (RAND_BITS > 0) begin : g_rand
      assign rand_ms = DELAY_W'(lfsr_q[RAND_BITS-1:0]);
   end else begin : g_norand
      assign rand_ms = '0;
   end

   assign busy  = (state_q == S_WAIT) || (state_q == S_STIM);
   assign state = state_q;

   // Sequencer, LFSR and millisecond counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lfsr_q       <= LFSR_SEED;
         delay_q      <= '0;
         ms_count     <= '0;
         entry_q      <= 1'b0;
         led          <= 1'b0;
         result_ms    <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_step(lfsr_q);
         result_valid <= 1'b0;
         entry_q      <= 1'b0;
         if (abort) begin
            entry_q <= (state_q != S_IDLE);
            state_q <= S_IDLE;
            led     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE, S_FALSE, S_TOUT: begin
                  // a simultaneous button is dropped: start wins here
                  if (start_pulse) begin
                     state_q     <= S_WAIT;
                     entry_q     <= 1'b1;
                     delay_q     <= DELAY_W'(MIN_DELAY_MS) + rand_ms;
                     false_start <= 1'b0;
                     timeout     <= 1'b0;
                  end
               end
               S_WAIT: begin
                  // the press is checked first so it beats the final tick
                  if (button_pulse) begin
                     state_q     <= S_FALSE;
                     entry_q     <= 1'b1;
                     false_start <= 1'b1;
                  end else if (tick) begin
                     delay_q <= (delay_q != '0) ? delay_q - DELAY_W'(1) : '0;
                     if (delay_q <= DELAY_W'(1)) begin
                        state_q  <= S_STIM;
                        entry_q  <= 1'b1;
                        led      <= 1'b1;
                        ms_count <= '0;
                     end
                  end
               end
               S_STIM: begin
                  // a tick in the press cycle is not counted
                  if (button_pulse) begin
                     state_q      <= S_DONE;
                     entry_q      <= 1'b1;
                     led          <= 1'b0;
                     result_ms    <= ms_count;
                     result_valid <= 1'b1;
                  end else if (tick) begin
                     ms_count <= ms_count + RESULT_W'(1);
                     if (ms_count == RESULT_W'(TIMEOUT_MS - 1)) begin
                        state_q      <= S_TOUT;
                        entry_q      <= 1'b1;
                        led          <= 1'b0;
                        timeout      <= 1'b1;
                        result_ms    <= RESULT_W'(TIMEOUT_MS);
                        result_valid <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  led     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
